mem_interface_pipelined: RTL and testbench

Parametrised successor to the single-cycle core memory interface. It is a word-addressed on-chip memory port with configurable read latency and in-order read responses buffered in a response FIFO. It has a credit-based request `ready` and consumer backpressure (`out_ready`). It sits between a core's fetch/LSU stage and local memory, and lets the core keep up to RESP_DEPTH reads outstanding.

---
 rtl/mem_interface_pipelined.sv | 144 ++++++++++++++
 tb/tb_mem_interface_pipelined.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface_pipelined.sv
// Word-addressed local memory port with a configurable read pipeline, an in-order
// first-word-fall-through response FIFO and credit-based request flow control.
module mem_interface_pipelined #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int LATENCY      = 2,
   parameter int RESP_DEPTH   = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      read,
   input  logic                      write,
   input  logic [ADDRESS_BITS-1:0]   address,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic [DATA_WIDTH/8-1:0]   byte_en,
   output logic                      ready,
   output logic                      out_valid,
   output logic [ADDRESS_BITS-1:0]   out_addr,
   output logic [DATA_WIDTH-1:0]     out_data,
   input  logic                      out_ready,
   output logic                      error,
   input  logic                      report
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RESP_DEPTH);

   logic [DATA_WIDTH-1:0]   mem [2**ADDRESS_BITS];

   logic                    read_accept;
   logic                    read_drop;
   logic                    pop;
   logic                    push_valid;
   logic [ADDRESS_BITS-1:0] push_addr;
   logic [DATA_WIDTH-1:0]   push_data;

   logic [ADDRESS_BITS-1:0] fifo_addr [RESP_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_data [RESP_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        fifo_count;
   logic [CNT_W-1:0]        outstanding;
   logic [31:0]             cycle_count;

   // A simultaneous write wins; the read is treated as dropped.
   assign read_accept = read & ~write & ready;
   assign read_drop   = read & (write | ~ready);
   assign ready       = (outstanding < DEPTH_CNT);
   assign out_valid   = (fifo_count != '0);
   assign pop         = out_valid & out_ready;
   assign out_addr    = out_valid ? fifo_addr[rd_ptr] : '0;
   assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;

   // NOTE: the array is never reset; contents survive reset and only bytes with
   // byte_en set are written, so the storage maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (write) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (byte_en[b]) mem[address][8*b +: 8] <= in_data[8*b +: 8];
         end
      end
   end

   // The FIFO write is the final register, so LATENCY-1 stages sit in front of it.
   if (LATENCY == 1) begin : g_direct
      assign push_valid = read_accept;
      assign push_addr  = address;
      assign push_data  = mem[address];
   end else begin : g_pipe
      logic                    stg_valid [LATENCY-1];
      logic [ADDRESS_BITS-1:0] stg_addr  [LATENCY-1];
      logic [DATA_WIDTH-1:0]   stg_data  [LATENCY-1];

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the value its predecessor held before the edge.
      always_ff @(posedge clock) begin
         if (reset) begin
            for (int i = 0; i < LATENCY-1; i++) stg_valid[i] <= 1'b0;
         end else begin
            stg_valid[0] <= read_accept;
            for (int i = 1; i < LATENCY-1; i++) stg_valid[i] <= stg_valid[i-1];
         end
      end

      always_ff @(posedge clock) begin
         stg_addr[0] <= address;
         stg_data[0] <= mem[address];
         for (int i = 1; i < LATENCY-1; i++) begin
            stg_addr[i] <= stg_addr[i-1];
            stg_data[i] <= stg_data[i-1];
         end
      end

      assign push_valid = stg_valid[LATENCY-2];
      assign push_addr  = stg_addr[LATENCY-2];
      assign push_data  = stg_data[LATENCY-2];
   end

   always_ff @(posedge clock) begin
      if (push_valid) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   // Credits count pipeline plus FIFO occupancy, so the FIFO can never overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         error       <= 1'b0;
         cycle_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (push_valid) wr_ptr <= wr_ptr + 1'b1;
         if (pop)        rd_ptr <= rd_ptr + 1'b1;
         case ({push_valid, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         case ({read_accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (read_drop) error <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (report) begin
         $display("core %0d cycle %0d: read=%b write=%b address=%h in_data=%h byte_en=%b ready=%b outstanding=%0d fifo_count=%0d out_valid=%b out_addr=%h out_data=%h error=%b",
                  CORE, cycle_count, read, write, address, in_data, byte_en, ready,
                  outstanding, fifo_count, out_valid, out_addr, out_data, error);
      end
   end

endmodule

// File: tb/tb_mem_interface_pipelined.sv
// Self-checking bench: directed scenarios plus a random phase, all compared each
// cycle against a transaction-level model (memory array + timed response queue).
module tb_mem_interface_pipelined;

   localparam int DW    = 32;
   localparam int AB    = 8;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int NB    = DW / 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          read;
   logic          write;
   logic [AB-1:0] address;
   logic [DW-1:0] in_data;
   logic [NB-1:0] byte_en;
   logic          ready;
   logic          out_valid;
   logic [AB-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          error;
   logic          report;

   mem_interface_pipelined #(
      .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
      .in_data(in_data), .byte_en(byte_en), .ready(ready), .out_valid(out_valid),
      .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready), .error(error),
      .report(report)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AB-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } resp_t;

   resp_t         exp_q[$];
   logic [DW-1:0] mem_model [2**AB];
   logic          err_model;
   int            cyc    = 0;
   int            passed = 0;
   int            total  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic rd, input logic wr, input logic [AB-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] be, input logic ordy);
      logic          head_valid;
      logic [AB-1:0] head_addr;
      logic [DW-1:0] head_data;
      bit            has_credit;
      read = rd; write = wr; address = a; in_data = d; byte_en = be; out_ready = ordy;
      has_credit = (exp_q.size() < DEPTH);
      head_valid = 1'b0;
      head_addr  = '0;
      head_data  = '0;
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         head_valid = 1'b1;
         head_addr  = exp_q[0].addr;
         head_data  = exp_q[0].data;
      end
      check("ready",     64'(ready),     64'(has_credit));
      check("out_valid", 64'(out_valid), 64'(head_valid));
      check("out_addr",  64'(out_addr),  64'(head_addr));
      check("out_data",  64'(out_data),  64'(head_data));
      check("error",     64'(error),     64'(err_model));
      if (wr) begin
         for (int b = 0; b < NB; b++) if (be[b]) mem_model[a][8*b +: 8] = d[8*b +: 8];
         if (rd) err_model = 1'b1;
      end else if (rd) begin
         if (has_credit) exp_q.push_back('{a, mem_model[a], cyc + LAT});
         else err_model = 1'b1;
      end
      if (head_valid && ordy) void'(exp_q.pop_front());
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1; read = 1'b0; write = 1'b0; out_ready = 1'b0; byte_en = '0;
      @(posedge clock);
      #1;
      cyc++;
      reset = 1'b0;
      exp_q.delete();
      err_model = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; in_data = '0;
      byte_en = '0; out_ready = 1'b0; report = 1'b0; err_model = 1'b0;
      @(posedge clock);
      #1;
      cyc++;
      do_reset();

      // Reset state
      check("rst_ready",     64'(ready),     64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_addr",  64'(out_addr),  64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_error",     64'(error),     64'd0);

      // Give every word a known value so random reads are well defined
      for (int i = 0; i < 2**AB; i++) step(1'b0, 1'b1, AB'(i), $urandom, '1, 1'b1);

      // Full write then read with LATENCY=2 timing
      step(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      step(1'b1, 1'b0, 8'h10, '0, '0, 1'b1);
      check("lat_early_valid", 64'(out_valid), 64'd0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0);
      check("lat_valid",  64'(out_valid), 64'd1);
      check("lat_addr",   64'(out_addr),  64'h10);
      check("lat_data",   64'(out_data),  64'hDEADBEEF);
      drain();

      // Partial write with byte enables
      step(1'b0, 1'b1, 8'h20, 32'h11223344, 4'hF, 1'b1);
      step(1'b0, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 1'b1);
      step(1'b1, 1'b0, 8'h20, '0, '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0);
      check("partial_data", 64'(out_data), 64'h11BB33DD);
      drain();

      // Back-to-back reads at full throughput
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AB'(i), '0, '0, 1'b1);
      check("b2b_tail_addr", 64'(out_addr), 64'd6);
      drain();

      // Credit exhaustion with a stalled consumer
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, AB'(i), '0, '0, 1'b0);
      check("credit_ready", 64'(ready), 64'd0);
      check("credit_error", 64'(error), 64'd1);
      check("credit_head",  64'(out_addr), 64'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      check("credit_return", 64'(ready), 64'd1);
      drain();

      // Read and write together: write wins, no response, sticky error
      do_reset();
      step(1'b1, 1'b1, 8'h30, 32'h55, 4'hF, 1'b1);
      check("rw_error", 64'(error), 64'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      step(1'b1, 1'b0, 8'h30, '0, '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0);
      check("rw_mem_data", 64'(out_data), 64'h55);
      check("rw_error_sticky", 64'(error), 64'd1);
      drain();

      // Reset with reads in flight
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, AB'(8'h10 + 8'(i)), '0, '0, 1'b0);
      do_reset();
      check("inflight_valid", 64'(out_valid), 64'd0);
      check("inflight_ready", 64'(ready), 64'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      step(1'b1, 1'b0, 8'h10, '0, '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0);
      check("retained_data", 64'(out_data), 64'hDEADBEEF);
      drain();

      report = 1'b1;
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      report = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 20),
              AB'($urandom_range(0, 15)), $urandom, NB'($urandom_range(0, 15)),
              ($urandom_range(0, 99) < 60));
      end
      drain();

      do_reset();
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      check("final_error_clear", 64'(error), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
